// File: rtl/processor_control.sv
// Control sequencer for the 16-bit multicycle processor: captures one instruction per
// fixed-length slot and walks a T0..T3 timing FSM that drives the datapath strobes.
module processor_control #(
    parameter int unsigned SLOT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] lin,
    output logic        ir_en,
    output logic [7:0]  r_in,
    output logic        a_in,
    output logic        g_in,
    output logic [1:0]  alu_op,
    output logic [3:0]  bus_sel,
    output logic [15:0] imm_val,
    output logic        out_en,
    output logic        done,
    output logic        halted
);

    localparam int unsigned IW    = 16;
    localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] BUS_G    = 4'd8;
    localparam logic [3:0] BUS_IMM  = 4'd9;
    localparam logic [3:0] BUS_IDLE = 4'd10;

    localparam logic [2:0] OP_OUT  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_WAIT,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     ir_q, ir_d;

    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       is_alu;
    logic       slot_wrap;
    logic [7:0] rx_onehot;
    state_e     after_done;

    assign op        = ir_q[15:13];
    assign rx        = ir_q[12:10];
    assign ry        = ir_q[9:7];
    assign is_alu    = ~op[2];
    assign slot_wrap = (cnt_q == CNT_LAST);
    assign rx_onehot = 8'b0000_0001 << rx;

    // A finishing instruction lands directly in T0 if its last cycle is also the slot's last.
    assign after_done = slot_wrap ? S_T0 : S_WAIT;

    assign imm_val = {6'b0, ir_q[9:0]};
    assign halted  = (state_q == S_HALT);

    // State, slot counter and instruction register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_T0;
            cnt_q   <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
        end
    end

    // Slot counter runs freely except while halted.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != S_HALT) begin
            cnt_d = slot_wrap ? '0 : cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        ir_d = ir_q;
        if (state_q == S_T0) begin
            ir_d = lin;
        end
    end

    // Next-state and per-cycle datapath controls, decoded from state and IR only.
    always_comb begin
        state_d = state_q;
        ir_en   = 1'b0;
        r_in    = 8'h00;
        a_in    = 1'b0;
        g_in    = 1'b0;
        alu_op  = 2'd0;
        bus_sel = BUS_IDLE;
        out_en  = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            S_T0: begin
                ir_en   = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                if (is_alu) begin
                    bus_sel = {1'b0, rx};
                    a_in    = 1'b1;
                    state_d = S_T2;
                end else begin
                    unique case (op)
                        OP_LDI: begin
                            bus_sel = BUS_IMM;
                            r_in    = rx_onehot;
                            done    = 1'b1;
                            state_d = after_done;
                        end
                        OP_MOV: begin
                            bus_sel = {1'b0, ry};
                            r_in    = rx_onehot;
                            done    = 1'b1;
                            state_d = after_done;
                        end
                        OP_OUT: begin
                            bus_sel = {1'b0, rx};
                            out_en  = 1'b1;
                            done    = 1'b1;
                            state_d = after_done;
                        end
                        OP_HALT: begin
                            done    = 1'b1;
                            state_d = S_HALT;
                        end
                        default: begin
                            state_d = after_done;
                        end
                    endcase
                end
            end
            S_T2: begin
                bus_sel = {1'b0, ry};
                g_in    = 1'b1;
                alu_op  = ir_q[14:13];
                state_d = S_T3;
            end
            S_T3: begin
                bus_sel = BUS_G;
                r_in    = rx_onehot;
                done    = 1'b1;
                state_d = after_done;
            end
            S_WAIT: begin
                if (slot_wrap) begin
                    state_d = S_T0;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_T0;
            end
        endcase
    end

endmodule

// File: tb/tb_processor_control.sv
// Directed bench for processor_control: hand-computed per-cycle control vectors for a
// 4-cycle slot build, plus an ir_en cadence check on a 6-cycle slot build.
module tb_processor_control;

    logic        clk;
    logic        resetn;
    logic [15:0] lin;
    logic        ir_en;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic [1:0]  alu_op;
    logic [3:0]  bus_sel;
    logic [15:0] imm_val;
    logic        out_en;
    logic        done;
    logic        halted;

    logic        resetn6;
    logic [15:0] lin6;
    logic        ir_en6;
    logic [7:0]  r_in6;
    logic        a_in6;
    logic        g_in6;
    logic [1:0]  alu_op6;
    logic [3:0]  bus_sel6;
    logic [15:0] imm_val6;
    logic        out_en6;
    logic        done6;
    logic        halted6;

    int n_checks;
    int n_errors;

    processor_control #(.SLOT_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn), .lin(lin), .ir_en(ir_en), .r_in(r_in),
        .a_in(a_in), .g_in(g_in), .alu_op(alu_op), .bus_sel(bus_sel),
        .imm_val(imm_val), .out_en(out_en), .done(done), .halted(halted)
    );

    processor_control #(.SLOT_CYCLES(6)) dut6 (
        .clk(clk), .resetn(resetn6), .lin(lin6), .ir_en(ir_en6), .r_in(r_in6),
        .a_in(a_in6), .g_in(g_in6), .alu_op(alu_op6), .bus_sel(bus_sel6),
        .imm_val(imm_val6), .out_en(out_en6), .done(done6), .halted(halted6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive lin for the current cycle, check every control output, advance one cycle.
    task automatic cyc(input string tag, input logic [15:0] lv, input logic e_ir,
                       input logic [7:0] e_r, input logic e_a, input logic e_g,
                       input logic [1:0] e_op, input logic [3:0] e_bus,
                       input logic e_out, input logic e_done, input logic e_halt);
        lin = lv;
        #1;
        check({tag, ".ir_en"},   32'(ir_en),   32'(e_ir));
        check({tag, ".r_in"},    32'(r_in),    32'(e_r));
        check({tag, ".a_in"},    32'(a_in),    32'(e_a));
        check({tag, ".g_in"},    32'(g_in),    32'(e_g));
        check({tag, ".alu_op"},  32'(alu_op),  32'(e_op));
        check({tag, ".bus_sel"}, 32'(bus_sel), 32'(e_bus));
        check({tag, ".out_en"},  32'(out_en),  32'(e_out));
        check({tag, ".done"},    32'(done),    32'(e_done));
        check({tag, ".halted"},  32'(halted),  32'(e_halt));
        @(negedge clk);
    endtask

    task automatic t0(input string tag, input logic [15:0] lv);
        cyc(tag, lv, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 4'd10, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag, input logic [15:0] lv);
        cyc(tag, lv, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 4'd10, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset values of everything except ir_en, which follows the reset state T0.
    task automatic rst_chk(input string tag);
        check({tag, ".r_in"},    32'(r_in),    32'h0);
        check({tag, ".a_in"},    32'(a_in),    32'h0);
        check({tag, ".g_in"},    32'(g_in),    32'h0);
        check({tag, ".alu_op"},  32'(alu_op),  32'h0);
        check({tag, ".bus_sel"}, 32'(bus_sel), 32'd10);
        check({tag, ".imm_val"}, 32'(imm_val), 32'h0);
        check({tag, ".out_en"},  32'(out_en),  32'h0);
        check({tag, ".done"},    32'(done),    32'h0);
        check({tag, ".halted"},  32'(halted),  32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b0;
        resetn6  = 1'b0;
        lin      = 16'h0000;
        lin6     = 16'hA01C;
        repeat (2) @(negedge clk);
        rst_chk("reset");

        // LDI r0,#28
        resetn = 1'b1;
        t0("ldi0.c0", 16'hA01C);
        check("ldi0.imm", 32'(imm_val), 32'd28);
        cyc("ldi0.c1", 16'hA01C, 1'b0, 8'h01, 1'b0, 1'b0, 2'd0, 4'd9, 1'b0, 1'b1, 1'b0);
        idle("ldi0.c2", 16'hA01C);
        idle("ldi0.c3", 16'hA01C);

        // LDI r1,#10
        t0("ldi1.c0", 16'hA40A);
        check("ldi1.imm", 32'(imm_val), 32'd10);
        cyc("ldi1.c1", 16'hA40A, 1'b0, 8'h02, 1'b0, 1'b0, 2'd0, 4'd9, 1'b0, 1'b1, 1'b0);
        idle("ldi1.c2", 16'hA40A);
        idle("ldi1.c3", 16'hA40A);

        // SUB r0,r1 with lin changed to LDI r1,#1023 during cycle 2
        t0("sub.c0", 16'h2080);
        cyc("sub.c1", 16'h2080, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc("sub.c2", 16'hA7FF, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        cyc("sub.c3", 16'hA7FF, 1'b0, 8'h01, 1'b0, 1'b0, 2'd0, 4'd8, 1'b0, 1'b1, 1'b0);

        // The late word executes in the following slot
        t0("ldi7.c0", 16'hA7FF);
        check("ldi7.imm", 32'(imm_val), 32'd1023);
        cyc("ldi7.c1", 16'hA7FF, 1'b0, 8'h02, 1'b0, 1'b0, 2'd0, 4'd9, 1'b0, 1'b1, 1'b0);
        idle("ldi7.c2", 16'hA7FF);
        idle("ldi7.c3", 16'hA7FF);

        // OUT r0 held for a whole slot: a single out_en pulse
        t0("out.c0", 16'h8000);
        cyc("out.c1", 16'h8000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        idle("out.c2", 16'h8000);
        idle("out.c3", 16'h8000);

        // SUB r0,r0 (rx == ry)
        t0("subrr.c0", 16'h2000);
        cyc("subrr.c1", 16'h2000, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc("subrr.c2", 16'h2000, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc("subrr.c3", 16'h2000, 1'b0, 8'h01, 1'b0, 1'b0, 2'd0, 4'd8, 1'b0, 1'b1, 1'b0);

        // AND r2,r3
        t0("and.c0", 16'h4980);
        cyc("and.c1", 16'h4980, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 4'd2, 1'b0, 1'b0, 1'b0);
        cyc("and.c2", 16'h4980, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 4'd3, 1'b0, 1'b0, 1'b0);
        cyc("and.c3", 16'h4980, 1'b0, 8'h04, 1'b0, 1'b0, 2'd0, 4'd8, 1'b0, 1'b1, 1'b0);

        // OR r7,r5
        t0("or.c0", 16'h7E80);
        cyc("or.c1", 16'h7E80, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 4'd7, 1'b0, 1'b0, 1'b0);
        cyc("or.c2", 16'h7E80, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 4'd5, 1'b0, 1'b0, 1'b0);
        cyc("or.c3", 16'h7E80, 1'b0, 8'h80, 1'b0, 1'b0, 2'd0, 4'd8, 1'b0, 1'b1, 1'b0);

        // MOV r6,r3
        t0("mov.c0", 16'hD980);
        cyc("mov.c1", 16'hD980, 1'b0, 8'h40, 1'b0, 1'b0, 2'd0, 4'd3, 1'b0, 1'b1, 1'b0);
        idle("mov.c2", 16'hD980);
        idle("mov.c3", 16'hD980);

        // ADD r4,r4
        t0("add.c0", 16'h1200);
        cyc("add.c1", 16'h1200, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 4'd4, 1'b0, 1'b0, 1'b0);
        cyc("add.c2", 16'h1200, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 4'd4, 1'b0, 1'b0, 1'b0);
        cyc("add.c3", 16'h1200, 1'b0, 8'h10, 1'b0, 1'b0, 2'd0, 4'd8, 1'b0, 1'b1, 1'b0);

        // Reset asserted during SUB cycle 2
        t0("subrst.c0", 16'h2080);
        cyc("subrst.c1", 16'h2080, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        rst_chk("midrst");
        @(negedge clk);
        rst_chk("midrst.hold");
        resetn = 1'b1;
        t0("rstart.c0", 16'hA01C);
        cyc("rstart.c1", 16'hA01C, 1'b0, 8'h01, 1'b0, 1'b0, 2'd0, 4'd9, 1'b0, 1'b1, 1'b0);
        idle("rstart.c2", 16'hA01C);
        idle("rstart.c3", 16'hA01C);

        // HALT, then 20 cycles of arbitrary lin with no activity
        t0("halt.c0", 16'hE000);
        cyc("halt.c1", 16'hE000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 4'd10, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("halted.%0d", i), 16'($urandom), 1'b0, 8'h00, 1'b0, 1'b0,
                2'd0, 4'd10, 1'b0, 1'b0, 1'b1);
        end

        // Six-cycle slot build: ir_en every 6th cycle, done one cycle later
        resetn6 = 1'b1;
        for (int k = 0; k < 24; k++) begin
            #1;
            check($sformatf("slot6.ir_en.%0d", k), 32'(ir_en6), 32'((k % 6) == 0));
            check($sformatf("slot6.done.%0d", k),  32'(done6),  32'((k % 6) == 1));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/processor_control.md
Name: processor_control

Overview:
- Control unit that sequences the 16-bit multicycle processor datapath: register file, A/G ALU registers, shared bus mux and output port.
- Captures the instruction on `lin` once per fixed-length instruction slot and steps a T0–T3 timing FSM.
- Emits per-cycle register enables, bus source select, ALU op, immediate value, output strobe and done.
- Sits between the instruction source driving `lin` and the datapath in `processor`.

Parameters:
- SLOT_CYCLES, 4: clock cycles per instruction slot; IR captured on slot cycle 0; legal values 4..16.

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous, active-low reset.
- lin  input  16  instruction word; sampled only on slot cycle 0.
- ir_en  output  1  IR load strobe (slot cycle 0).
- r_in  output  8  one-hot write enable for R0..R7 (bus -> Rx).
- a_in  output  1  load ALU operand register A from bus.
- g_in  output  1  load ALU result register G.
- alu_op  output  2  0 ADD, 1 SUB, 2 AND, 3 OR.
- bus_sel  output  4  0..7 = R0..R7, 8 = G, 9 = immediate, 10 = zero/idle.
- imm_val  output  16  {6'b0, IR[9:0]}.
- out_en  output  1  latch bus into output port.
- done  output  1  one-cycle pulse on the final execute cycle of an instruction.
- halted  output  1  high while in HALT.

Behaviour:
- Encoding: op = IR[15:13], rx = IR[12:10], ry = IR[9:7], imm = IR[9:0].
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 OUT rx, 101 LDI rx,#imm, 110 MOV rx,ry, 111 HALT.
- Reset (async, resetn=0):
  - state=T0, slot counter=0, IR=0, halted=0.
  - All enables 0, alu_op=0, bus_sel=10, imm_val=0, done=0.
  - Takes effect immediately mid-instruction; no partial writes complete afterwards.
- Slot counter: 0..SLOT_CYCLES-1, wraps to 0. Runs freely except in HALT. Instruction N occupies slot N.
- FSM states: T0, T1, T2, T3, WAIT, HALT.
- Outputs decode from the registered state and IR only; there is no combinational path from `lin`, except `ir_en`, which depends on state alone.
- T0 (slot cycle 0): ir_en=1, IR<=lin at the clock edge, next state T1.
- T1:
  - ALU ops: bus_sel=rx, a_in=1 -> T2.
  - LDI: bus_sel=9, r_in[rx]=1, done=1 -> WAIT.
  - MOV: bus_sel=ry, r_in[rx]=1, done=1 -> WAIT.
  - OUT: bus_sel=rx, out_en=1, done=1 -> WAIT.
  - HALT: done=1 -> HALT.
- T2 (ALU only): bus_sel=ry, g_in=1, alu_op=IR[14:13] -> T3.
- T3 (ALU only): bus_sel=8, r_in[rx]=1, done=1 -> WAIT.
- WAIT: all strobes 0, bus_sel=10. Go to T0 when the slot counter wraps to 0.
  - Short instructions therefore never re-execute a held `lin`.
- HALT: all strobes 0, halted=1, counter frozen. Exit only via reset.
- MOV rx,rx and ALU ops with rx=ry are legal; there is no special casing.
- A `lin` change during slot cycles 1..SLOT_CYCLES-1 is ignored.
- Exactly one bit of r_in is high when r_in is non-zero. No cycle asserts both a_in and g_in.

Test Plan:
- Reset hold 2 cycles, release, lin=16'hA01C (LDI r0,#28) -> slot cycle 0 ir_en=1; cycle 1 bus_sel=9, imm_val=28, r_in=8'h01, done=1; cycles 2–3 idle (bus_sel=10).
- lin=16'hA40A (LDI r1,#10) then 16'h2080 (SUB r0,r1):
  - SUB cycle 1: bus_sel=0, a_in=1.
  - SUB cycle 2: bus_sel=1, g_in=1, alu_op=1.
  - SUB cycle 3: bus_sel=8, r_in=8'h01, done=1.
- lin=16'h8000 (OUT r0) held 4 cycles -> exactly one out_en pulse with bus_sel=0; no second pulse in the next slot unless `lin` is re-captured.
- Change `lin` to 16'hA7FF on SUB cycle 2 -> SUB completes unchanged; the new word executes in the next slot.
- Assert resetn=0 during SUB cycle 2 -> outputs return to reset values immediately; no r_in pulse; after release the FSM restarts at T0.
- lin=16'hE000 (HALT) -> done pulse at cycle 1, then halted=1; all strobes stay 0 for 20 cycles regardless of `lin`.
- With SLOT_CYCLES=6 -> ir_en pulses exactly every 6 cycles.
